// File: rtl/counter32_pkg.sv
// counter32_pkg: shared constants and types for the counter32 step counter.
//   CNT_W   - counter width in bits (5)
//   CNT_MAX - terminal count value (31)
//   cnt_t   - count value type
`timescale 1ns/1ps
package counter32_pkg;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/counter32_tff.sv
// tff: toggle flip-flop, the per-bit cell of counter32.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, forces q to 0
//   t   - toggle request, sampled on the rising edge of clk
//   q   - flop output
`timescale 1ns/1ps
module tff
    import counter32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/counter32.sv
// counter32: free-running modulo-32 up-counter with synchronous count enable
// and asynchronous active-high reset. Built from CNT_W toggle flops sharing
// one clock; bit i toggles when en is high and all lower bits are 1.
// Optional feature macro: COUNTER32_TC_EN adds the terminal-count output tc.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, count forced to 0
//   en    - count enable, sampled on the rising edge of clk
//   count - current count value (0..31), driven directly from flops
//   tc    - (COUNTER32_TC_EN only) high when count is 31 and en is high,
//           i.e. the next edge wraps the counter
`timescale 1ns/1ps
module counter32
    import counter32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t count
`ifdef COUNTER32_TC_EN
    ,
    output logic tc
`endif
);

    // Toggle chain: t_chain[i] = en & count[0] & ... & count[i-1].
    // Carry out of the top bit is not needed, so the chain stops at CNT_W-1.
    logic [CNT_W-1:0] t_chain;

    assign t_chain[0] = en;

    for (genvar i = 1; i < CNT_W; i++) begin : g_chain
        assign t_chain[i] = t_chain[i-1] & count[i-1];
    end

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        tff u_tff (
            .clk (clk),
            .rst (rst),
            .t   (t_chain[i]),
            .q   (count[i])
        );
    end

`ifdef COUNTER32_TC_EN
    // count is held at 0 during reset, so tc is 0 there without gating on rst.
    assign tc = (count == CNT_MAX) && en;
`endif

endmodule

// File: tb/tb_counter32.sv
// tb_counter32: self-checking bench for counter32 (table-driven vectors with
// a scoreboard queue, plus hand-written reset corner sequences).
`timescale 1ns/1ps
module tb_counter32;
    import counter32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    cnt_t count;
`ifdef COUNTER32_TC_EN
    logic tc;
`endif

    counter32 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (count)
`ifdef COUNTER32_TC_EN
        ,
        .tc    (tc)
`endif
    );

    always #1 clk = ~clk;

    typedef struct {
        bit   rst_before;
        bit   en;
        cnt_t cnt;
    } vec_t;

    typedef struct {
        cnt_t cnt;
        bit   tc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input cnt_t exp_cnt, input bit exp_tc);
        vectors++;
        if (count !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s: count=%0d expected %0d at t=%0t", name, count, exp_cnt, $time);
        end
`ifdef COUNTER32_TC_EN
        vectors++;
        if (tc !== exp_tc) begin
            miscompares++;
            $display("FAIL %s_tc: tc=%b expected %b at t=%0t", name, tc, exp_tc, $time);
        end
`else
        if (exp_tc && (count !== CNT_MAX)) begin
            miscompares++;
            $display("FAIL %s_term: count=%0d expected %0d at t=%0t", name, count, CNT_MAX, $time);
        end
`endif
    endtask

    // Called at a falling edge: drive en, record the expectation, let one
    // rising edge happen, then compare at the following falling edge.
    task automatic step(input bit en_v, input cnt_t exp_cnt, input string name);
        exp_t e;
        en = en_v;
        exp_q.push_back('{cnt: exp_cnt, tc: (en_v && exp_cnt == CNT_MAX)});
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_sb: scoreboard empty, count=%0d", name, count);
        end else begin
            e = exp_q.pop_front();
            check(name, e.cnt, e.tc);
        end
    endtask

    // Called at a falling edge: pulse rst between clock edges, check the
    // asynchronous clear, and return at the next falling edge with count 0.
    task automatic reset_between_edges();
        en = 1'b0;
        #0.3 rst = 1'b1;
        #0.2 check("async_rst", '0, 1'b0);
        #0.3 rst = 1'b0;
        @(negedge clk);
        check("post_rst", '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, count=%0d", count);
        $fatal(1, "watchdog");
    end

    initial begin
        // Hold for 10 edges.
        for (int i = 0; i < 10; i++) vecs.push_back('{rst_before: 1'b0, en: 1'b0, cnt: 5'd0});
        // Count 40 edges: 1..31, 0, 1..8.
        for (int i = 0; i < 40; i++) vecs.push_back('{rst_before: 1'b0, en: 1'b1, cnt: 5'((i + 1) % 32)});
        // Enable gating: reset, count to 5, hold 4 edges, resume 6..8.
        vecs.push_back('{rst_before: 1'b1, en: 1'b1, cnt: 5'd1});
        for (int v = 2; v <= 5; v++) vecs.push_back('{rst_before: 1'b0, en: 1'b1, cnt: 5'(v)});
        for (int i = 0; i < 4; i++) vecs.push_back('{rst_before: 1'b0, en: 1'b0, cnt: 5'd5});
        for (int v = 6; v <= 8; v++) vecs.push_back('{rst_before: 1'b0, en: 1'b1, cnt: 5'(v)});

        // Power-on reset: 1-unit pulse spanning the first rising edge.
        #0.2 rst = 1'b1;
        #0.5 check("por_during", '0, 1'b0);
        @(posedge clk);
        #0.2 rst = 1'b0;
        #0.3 check("por_after", '0, 1'b0);
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) reset_between_edges();
            step(vecs[i].en, vecs[i].cnt, $sformatf("vec%0d", i));
        end

        // Async reset mid-count at 17, held across one edge with en=1.
        reset_between_edges();
        for (int v = 1; v <= 17; v++) step(1'b1, 5'(v), "to17");
        #0.4 rst = 1'b1;
        #0.1 check("mid_rst", '0, 1'b0);
        @(posedge clk);
        #0.3 check("rst_hold", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd1, "resume");

        // Reset coincident with the wrapping edge at count 31.
        for (int v = 2; v <= 31; v++) step(1'b1, 5'(v), "to31");
        @(posedge clk);
        rst = 1'b1;
        #0.3 check("coincident", '0, 1'b0);
        @(negedge clk);
        check("coincident_hold", '0, 1'b0);
        rst = 1'b0;
        step(1'b1, 5'd1, "after_coincident");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter32.md
# counter32

Free-running 5-bit modulo-32 up-counter with synchronous count enable and asynchronous reset. It counts 0..31, wraps to 0, and holds its value when disabled. It is the shared sequencing primitive for the processor datapath: multi-cycle operation step counters, such as the iterative multiply/divide control, instantiate it and decode `count`.

## Interface
Parameters:
- None. Width is fixed at 5 bits through the package constant.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; forces `count` to 0 immediately.
- `en`   in  1  count enable, sampled on the rising edge of `clk`.
- `count`  out  5  current count value, unsigned, range 0..31.
- `tc`  out  1  terminal count; present only when `COUNTER32_TC_EN` is defined.

## Operation
- `rst`=1: `count` is 0 asynchronously, without waiting for a clock edge. It stays 0 for as long as `rst` is held, regardless of `en` and `clk`.
- `rst`=0 and `en`=1 at a rising edge: `count` becomes (`count`+1) mod 32.
- `rst`=0 and `en`=0 at a rising edge: `count` holds its value.
- Wrap-around: 31 with `en`=1 goes to 0 at the next edge. There is no saturation and no sticky overflow flag.
- Arithmetic: unsigned 5-bit; the carry out of bit 4 is discarded.
- Implementation is synchronous: all five bits change on the same edge. Bit i toggles when `en` is 1 and bits 0..i-1 are all 1. Ripple-clocked implementations are not allowed.
- Reset mid-count: `count` returns to 0 within the same simulation time step, even between clock edges. Counting resumes from 0 at the first rising edge after `rst` falls with `en`=1.
- Simultaneous `rst` and clock edge: reset wins; `count` is 0.
- `en` toggling: takes effect only at clock edges. Glitches between edges have no effect.
- No X propagation from `en` while `rst`=1.

## Timing
- Latency: one clock cycle from an enabled edge to the updated `count`.
- `count` is driven directly from flops; there is no combinational path from `en` to `count`.
- Reset value of every output: `count`=5'b00000 and `tc`=0.
- Reset assertion is asynchronous. Reset release must meet recovery/removal relative to `clk`; the block does not synchronise `rst` internally.
- After release, with `en` held at 1, `count` reads 1 after the first edge, 31 after the 31st edge, and 0 after the 32nd edge.

## Configuration
- Macro: `COUNTER32_TC_EN`.
- Defined: adds output `tc`, a combinational signal equal to (`count`==31) AND `en`. It flags the cycle whose next edge wraps the counter, and is 0 during reset.
- Not defined: port `tc` and its logic are absent, and the interface is exactly `clk`, `rst`, `en`, `count`.

## Structure
- Shared package `counter32_pkg` holds:
  - `CNT_W` = 5
  - `CNT_MAX` = 5'd31
  - typedef `cnt_t` = logic [CNT_W-1:0]
- One sub-module, `tff`: a T flip-flop with inputs `clk`, `rst`, `t` and output `q`. It has async active-high reset to 0 and toggles `q` on a rising edge when `t`=1.
- The top level instantiates `CNT_W` `tff`s through a generate loop. Each bit's `t` is the AND of `en` and all lower `q` bits, computed as a carry-chain wire array.
- The optional `tc` decode lives in the top level, inside the macro guard.

## Test plan
- Power-on reset: `clk` period 2, `en`=0, pulse `rst`=1 for 1 time unit -> `count`=0 during and after the pulse; `tc`=0.
- Hold: `rst`=0, `en`=0 for 10 edges -> `count` remains 0.
- Count and wrap: `en`=1 for 40 edges after reset -> `count` goes 1,2,…,31,0,1,…,8. `tc`=1 only while `count`=31.
- Enable gating: count to 5, drop `en` for 4 edges, raise it again -> `count` stays 5 while disabled, then 6,7,…
- Async reset mid-count: at `count`=17, assert `rst` between clock edges -> `count`=0 before the next rising edge. After release with `en`=1, the next edge gives 1.
- Reset coincident with an edge while `en`=1 and `count`=31 -> `count`=0, not a wrap artefact; `tc`=0.
